// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit controller: FSM state encoding,
// default geometry and line-level bit values.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_DATA_TIMEOUT = 12;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// System-side handshake between the TX data source (master) and the
// transmit controller (slave).
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  busy;

    modport master (output p_data, data_valid, par_en, par_typ, input busy);
    modport slave  (input p_data, data_valid, par_en, par_typ, output busy);
endinterface

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Parity bit generator: even (par_typ=0) or odd (par_typ=1) over the byte.
// Only compiled when UART_TX_PARITY_EN is defined, since that is the only
// build that instantiates it.
`ifdef UART_TX_PARITY_EN
module parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_par_bit
);
    assign o_par_bit = (^i_data) ^ i_par_typ;
endmodule
`endif

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte, sequences start/data/parity/stop
// and drives the line, enabling the external serializer during the data
// phase. A DATA phase that outlasts DATA_TIMEOUT cycles aborts the frame.
// Optional feature macro: UART_TX_PARITY_EN (parity state and registers).
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DATA_TIMEOUT = DEF_DATA_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rest,
    uart_tx_ctrl_if.slave         sys,
    input  logic                  ser_dn,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  tx_out,
    output logic                  ser_timeout
);
    localparam int CNT_W = $clog2(DATA_TIMEOUT + 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_tmo;
    logic                  w_accept;

    // A new byte may enter while idle or during the stop bit (back-to-back).
    assign w_accept = sys.data_valid && (r_state == ST_IDLE || r_state == ST_STOP);

`ifdef UART_TX_PARITY_EN
    logic r_par_bit;
    logic r_par_en_q;
    logic w_par_bit;

    parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .i_data    (sys.p_data),
        .i_par_typ (sys.par_typ),
        .o_par_bit (w_par_bit)
    );
`else
    logic w_unused;
    assign w_unused = &{1'b0, sys.par_en, sys.par_typ};
`endif

    // Frame sequencer: state, latched byte, parity and DATA-phase watchdog.
    always_ff @(posedge clk) begin
        if (!rest) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_bit  <= 1'b0;
            r_par_en_q <= 1'b0;
`endif
        end else begin
            r_tmo <= 1'b0;
            if (w_accept) begin
                r_data <= sys.p_data;
`ifdef UART_TX_PARITY_EN
                r_par_bit  <= w_par_bit;
                r_par_en_q <= sys.par_en;
`endif
            end
            case (r_state)
                ST_IDLE:  if (w_accept) r_state <= ST_START;
                ST_START: begin
                    r_state <= ST_DATA;
                    r_cnt   <= '0;
                end
                ST_DATA: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (ser_dn) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= r_par_en_q ? ST_PARITY : ST_STOP;
`else
                        r_state <= ST_STOP;
`endif
                    end else if (r_cnt == CNT_W'(DATA_TIMEOUT - 1)) begin
                        // Serializer never finished: abort, release the line.
                        r_tmo   <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
                ST_PARITY: r_state <= ST_STOP;
                ST_STOP:   r_state <= w_accept ? ST_START : ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Line select per phase; only DATA passes an input straight through.
    always_comb begin
        tx_out = STOP_BIT;
        case (r_state)
            ST_START:  tx_out = START_BIT;
            ST_DATA:   tx_out = ser_data;
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_out = r_par_bit;
`endif
            default:   tx_out = STOP_BIT;
        endcase
    end

    assign ser_en      = (r_state == ST_START) || (r_state == ST_DATA);
    assign sys.busy    = (r_state != ST_IDLE);
    assign ser_p_data  = r_data;
    assign ser_timeout = r_tmo;

endmodule
